// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//
// Direct-mapped instruction cache for the fetch stage. A lookup is purely
// combinational from the fetch address. A miss refills one whole line from a
// word-wide memory port, one beat per acknowledged request. Beats are always
// fetched in order 0..LINE_WORDS-1.
//
// Ports
//   Clk           clock, all state changes on the rising edge
//   Rst           synchronous active-high reset
//   i_fetch_addr  instruction byte address from fetch
//   o_fetch_bus   {miss, instruction}; forced to zero while Rst is high
//   i_invalidate  single-cycle pulse: invalidate the whole cache
//   o_mem_req     refill beat request (high for the whole refill)
//   o_mem_addr    word-aligned byte address of the requested beat
//   i_mem_ack     beat accepted, i_mem_data valid in the same cycle
//   i_mem_data    refill word
// ---------------------------------------------------------------------------
module icache_direct #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] i_fetch_addr,
  output logic [32:0] o_fetch_bus,
  input  logic        i_invalidate,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - 2 - OFF_W - IDX_W;
  localparam int BASE_W = TAG_W + IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Storage: valid bits are reset, tag/data arrays are not.
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag_mem  [NUM_LINES];
  logic [31:0]          r_data_mem [NUM_LINES*LINE_WORDS];

  // Refill bookkeeping: line being filled, next beat, invalidate seen mid-fill.
  logic [BASE_W-1:0] r_base;
  logic [OFF_W-1:0]  r_beat;
  logic              r_inv_pending;

  // Address fields of the current fetch address.
  logic [OFF_W-1:0] w_word;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_base_idx;
  logic [TAG_W-1:0] w_base_tag;
  logic             w_addr_unused;

  assign w_word        = i_fetch_addr[OFF_W+1:2];
  assign w_idx         = i_fetch_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag         = i_fetch_addr[31:OFF_W+IDX_W+2];
  assign w_base_idx    = r_base[IDX_W-1:0];
  assign w_base_tag    = r_base[BASE_W-1:IDX_W];
  // Byte-within-word bits play no part in an instruction fetch.
  assign w_addr_unused = ^i_fetch_addr[1:0];

  logic w_hit;
  logic w_start;     // IDLE miss: latch the line and begin refilling
  logic w_beat_wr;   // accepted beat: write data, advance beat counter
  logic w_last;      // accepted final beat: write tag, settle valid bits

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_beat_wr    = 1'b0;
    w_last       = 1'b0;
    o_fetch_bus  = {1'b1, 32'b0};
    o_mem_req    = 1'b0;
    o_mem_addr   = 32'b0;

    w_hit = (r_state == S_IDLE) && r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);

    case (r_state)
      S_IDLE: begin
        if (!w_hit) begin
          w_start      = 1'b1;
          w_state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {r_base, r_beat, 2'b00};
        if (i_mem_ack) begin
          w_beat_wr = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_last       = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_hit) begin
      o_fetch_bus = {1'b0, r_data_mem[{w_idx, w_word}]};
    end

    // Reset forces every output quiet, even before the state register clears.
    if (Rst) begin
      o_fetch_bus = 33'b0;
      o_mem_req   = 1'b0;
      o_mem_addr  = 32'b0;
      w_start     = 1'b0;
      w_beat_wr   = 1'b0;
      w_last      = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Refill control and valid bits
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_base        <= '0;
      r_beat        <= '0;
      r_inv_pending <= 1'b0;
      r_valid       <= '0;
    end else begin
      if (w_start) begin
        r_base <= {w_tag, w_idx};
        r_beat <= '0;
      end
      // Counter is log2(LINE_WORDS) wide, so the final beat wraps it to 0.
      if (w_beat_wr) begin
        r_beat <= r_beat + OFF_W'(1);
      end

      if (r_state == S_IDLE) begin
        // An invalidate alongside a miss clears first; the miss still proceeds.
        if (i_invalidate) begin
          r_valid <= '0;
        end
      end else if (w_last) begin
        // An invalidate seen at any point of the refill kills the new line too.
        if (r_inv_pending || i_invalidate) begin
          r_valid <= '0;
        end else begin
          r_valid[w_base_idx] <= 1'b1;
        end
        r_inv_pending <= 1'b0;
      end else if (i_invalidate) begin
        r_inv_pending <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Tag and data arrays (written only by the refill engine)
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (w_beat_wr) begin
      r_data_mem[{w_base_idx, r_beat}] <= i_mem_data;
    end
    if (w_last) begin
      r_tag_mem[w_base_idx] <= w_base_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
//
// Drives icache_direct with directed scenarios followed by randomized
// traffic and compares every cycle against a line-level reference model of
// the cache (valid/tag/data per index plus one outstanding refill record).
// Instruction memory content is a fixed function of the word address.
// ---------------------------------------------------------------------------
module tb_icache_direct;

  localparam int LW = 4;
  localparam int NL = 64;

  logic        Clk;
  logic        Rst;
  logic [31:0] i_fetch_addr;
  logic [32:0] o_fetch_bus;
  logic        i_invalidate;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;

  icache_direct #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_fetch_addr (i_fetch_addr),
    .o_fetch_bus  (o_fetch_bus),
    .i_invalidate (i_invalidate),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (i_mem_ack),
    .i_mem_data   (i_mem_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory: each word holds 0xA0 plus its word number.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  // Reference model
  logic        m_valid [NL];
  logic [21:0] m_tag   [NL];
  logic [31:0] m_data  [NL][LW];
  logic        p_act  = 1'b0;
  logic [31:0] p_line = 32'b0;
  int          p_beat = 0;
  logic        p_kill = 1'b0;
  logic [31:0] p_buf [LW];

  // Memory responder settings/state
  int   fixed_lat = 2;
  logic rand_lat  = 1'b0;
  logic stray_en  = 1'b0;
  int   cnt = 0;
  int   lat = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;

  logic [32:0] last_bus;
  logic        last_exp_miss;

  task automatic clear_model();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  // One clock cycle: drive, respond, check against model, advance model.
  task automatic tick(input logic [31:0] addr, input logic inv, input logic rst);
    logic [32:0] exp_bus;
    logic        exp_req;
    logic [31:0] exp_maddr;
    logic        hit;
    int          idx;
    int          w;
    i_fetch_addr = addr;
    i_invalidate = inv;
    Rst          = rst;
    #1;
    if (o_mem_req) begin
      if (!prev_req || prev_ack) begin
        cnt = 0;
        lat = rand_lat ? int'($urandom_range(0, 2)) : fixed_lat;
      end else begin
        cnt++;
      end
      i_mem_ack = (cnt >= lat);
    end else begin
      i_mem_ack = stray_en && ($urandom_range(0, 3) == 0);
    end
    i_mem_data = i_mem_ack ? mem_word(o_mem_addr) : $urandom;
    prev_req = o_mem_req;
    prev_ack = i_mem_ack;
    #1;

    idx = int'(addr[9:4]);
    w   = int'(addr[3:2]);
    hit = 1'b0;
    if (rst) begin
      exp_bus = 33'b0; exp_req = 1'b0; exp_maddr = 32'b0;
    end else if (p_act) begin
      exp_bus = {1'b1, 32'b0}; exp_req = 1'b1; exp_maddr = p_line + 32'(p_beat * 4);
    end else begin
      hit       = m_valid[idx] && (m_tag[idx] == addr[31:10]);
      exp_bus   = hit ? {1'b0, m_data[idx][w]} : {1'b1, 32'b0};
      exp_req   = 1'b0;
      exp_maddr = 32'b0;
    end
    chk("fetch_bus", o_fetch_bus, exp_bus);
    chk("mem_req", 33'(o_mem_req), 33'(exp_req));
    chk("mem_addr", 33'(o_mem_addr), 33'(exp_maddr));
    last_bus      = o_fetch_bus;
    last_exp_miss = exp_bus[32];

    if (rst) begin
      clear_model();
      p_act = 1'b0;
    end else if (p_act) begin
      if (inv) p_kill = 1'b1;
      if (i_mem_ack) begin
        p_buf[p_beat] = mem_word(p_line + 32'(p_beat * 4));
        p_beat++;
        if (p_beat == LW) begin
          p_act = 1'b0;
          if (p_kill) begin
            clear_model();
          end else begin
            m_valid[int'(p_line[9:4])] = 1'b1;
            m_tag[int'(p_line[9:4])]   = p_line[31:10];
            for (int b = 0; b < LW; b++) m_data[int'(p_line[9:4])][b] = p_buf[b];
          end
        end
      end
    end else begin
      if (!hit) begin
        p_act  = 1'b1;
        p_line = {addr[31:4], 4'b0};
        p_beat = 0;
        p_kill = 1'b0;
      end
      if (inv) clear_model();
    end

    @(posedge Clk);
    #1;
  endtask

  // Present addr until the model says it hits; count DUT miss cycles.
  task automatic fill(input logic [31:0] addr, output int misses);
    logic done;
    done   = 1'b0;
    misses = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      tick(addr, 1'b0, 1'b0);
      if (last_bus[32]) misses++;
      if (!last_exp_miss) done = 1'b1;
    end
    chk("fill_bound", 33'(done), 33'd1);
  endtask

  // Present addr until the outstanding refill has completed beat b-1.
  task automatic run_to_beat(input logic [31:0] addr, input int b);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (p_act && p_beat == b) done = 1'b1;
      else tick(addr, 1'b0, 1'b0);
    end
    chk("beat_bound", 33'(done), 33'd1);
  endtask

  initial begin
    int          misses;
    logic [31:0] cur;
    i_fetch_addr = 32'b0;
    i_invalidate = 1'b0;
    i_mem_ack    = 1'b0;
    i_mem_data   = 32'b0;
    Rst          = 1'b1;
    clear_model();

    // Reset
    for (int i = 0; i < 3; i++) tick(32'h0, 1'b0, 1'b1);

    // Cold miss: 1 + 4*3 miss cycles, then {0, 0xA0}
    fill(32'h0, misses);
    chk("cold_miss_cycles", 33'(misses), 33'd13);
    chk("cold_hit_data", last_bus, {1'b0, 32'hA0});

    // Hits after fill
    tick(32'h4, 1'b0, 1'b0); chk("hit_4", last_bus, {1'b0, 32'hA1});
    tick(32'h8, 1'b0, 1'b0); chk("hit_8", last_bus, {1'b0, 32'hA2});
    tick(32'hC, 1'b0, 1'b0); chk("hit_C", last_bus, {1'b0, 32'hA3});

    // Conflict eviction on index 0
    fill(32'h400, misses);
    chk("conflict_400_miss", 33'(misses), 33'd13);
    fill(32'h0, misses);
    chk("conflict_0_miss", 33'(misses), 33'd13);

    // Redirect mid-refill
    run_to_beat(32'h100, 2);
    fill(32'h200, misses);
    tick(32'h100, 1'b0, 1'b0);
    chk("redirect_100_hit", last_bus, {1'b0, mem_word(32'h100)});

    // Invalidate in IDLE
    tick(32'h0, 1'b1, 1'b0);
    tick(32'h0, 1'b0, 1'b0);
    chk("inv_idle_miss", 33'(last_bus[32]), 33'd1);
    fill(32'h0, misses);

    // Invalidate during refill of 0x300: line must refill a second time
    run_to_beat(32'h300, 1);
    tick(32'h300, 1'b1, 1'b0);
    fill(32'h300, misses);
    chk("inv_refill_twice", 33'(misses > 13), 33'd1);

    // Reset mid-refill
    fill(32'h0, misses);
    tick(32'h400, 1'b0, 1'b0);
    run_to_beat(32'h0, 3);
    tick(32'h0, 1'b0, 1'b1);
    chk("rst_bus", last_bus, 33'b0);
    chk("rst_req", 33'(o_mem_req), 33'd0);
    tick(32'h0, 1'b0, 1'b1);
    fill(32'h0, misses);
    chk("rst_refill_miss", 33'(misses), 33'd13);

    // Randomized traffic: variable latency, stray acks, rare invalidate/reset
    rand_lat = 1'b1;
    stray_en = 1'b1;
    cur = 32'h0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cur = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
            | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      end
      tick(cur, $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
